// File: rtl/ldtu_pkg.sv
// rtl/ldtu_pkg.sv - shared constants for the LiteDTU output serializer
//
// Purpose: lane word width, bit counter width and the idle patterns that are
// shared with the upstream 32-bit output mux.
// Contents:
//   Nbits_32        lane word width
//   CNT_W           bit counter width, log2(Nbits_32)
//   NUM_LANES       number of serial lanes
//   IDLE_EA/IDLE_5A reset contents of the lane shift registers
//   CNT_LAST        terminal count; the edge leaving it is a load edge
//   lane_reset_val  idle pattern assigned to a given lane index

package ldtu_pkg;

    localparam int Nbits_32  = 32;
    localparam int CNT_W     = 5;
    localparam int NUM_LANES = 4;

    localparam logic [Nbits_32-1:0] IDLE_EA = 32'hEAAAAAAA;
    localparam logic [Nbits_32-1:0] IDLE_5A = 32'h5A5A5A5A;

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    // Lane 0 carries DTU data and idles with EA; ATU lanes idle with 5A.
    function automatic logic [Nbits_32-1:0] lane_reset_val(input int lane);
        return (lane == 0) ? IDLE_EA : IDLE_5A;
    endfunction

endpackage

// File: rtl/ldtu_serializer_4lane_if.sv
// rtl/ldtu_serializer_4lane_if.sv - lane word / serial output bundle of the serializer
//
// Purpose: groups the upstream-facing lane words and controls together with
// the serial outputs and status strobes.
// Signals:
//   data32      [lane] lane words, sampled only on the load edge
//   lane_en     per-lane enable, sampled on the load edge
//   sync        word-boundary resync request, single-cycle pulse
//   ser         serial lane outputs, MSB-first
//   word_strobe high during the cycle whose closing edge loads new words
//   sync_ack    one-cycle pulse after a sync-forced load
// Modports:
//   master      upstream side (drives words and controls)
//   slave       serializer side

interface ldtu_serializer_4lane_if;
    import ldtu_pkg::*;

    logic [NUM_LANES-1:0][Nbits_32-1:0] data32;
    logic [NUM_LANES-1:0]               lane_en;
    logic                               sync;
    logic [NUM_LANES-1:0]               ser;
    logic                               word_strobe;
    logic                               sync_ack;

    modport master (
        output data32,
        output lane_en,
        output sync,
        input  ser,
        input  word_strobe,
        input  sync_ack
    );

    modport slave (
        input  data32,
        input  lane_en,
        input  sync,
        output ser,
        output word_strobe,
        output sync_ack
    );

endinterface

// File: rtl/ldtu_lane_shifter.sv
// rtl/ldtu_lane_shifter.sv - one 32-bit load/shift register driving a serial lane
//
// Purpose: holds one lane word and shifts it out MSB-first, one bit per clock.
// Ports:
//   i_clk   serial bit clock
//   i_rst   synchronous active-high reset, loads RESET_VAL
//   i_load  load edge strobe from the shared bit counter
//   i_en    lane enable; a disabled lane loads all zeros
//   i_data  lane word to load
//   o_ser   serial output, bit 31 of the register (no output flop)

module ldtu_lane_shifter
    import ldtu_pkg::*;
#(
    parameter logic [Nbits_32-1:0] RESET_VAL = IDLE_5A
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic                i_en,
    input  logic [Nbits_32-1:0] i_data,
    output logic                o_ser
);

    logic [Nbits_32-1:0] r_sr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr <= RESET_VAL;
        end else if (i_load) begin
            r_sr <= i_en ? i_data : '0;
        end else begin
            r_sr <= {r_sr[Nbits_32-2:0], 1'b0};
        end
    end

    assign o_ser = r_sr[Nbits_32-1];

endmodule

// File: rtl/ldtu_serializer_4lane.sv
// rtl/ldtu_serializer_4lane.sv - four-lane 32:1 serializer behind the LiteDTU output mux
//
// Purpose: shifts four lane words out MSB-first on four serial lines sharing
// one bit counter, paces the upstream mux with a word strobe and realigns
// word boundaries on a sync request.
// Ports:
//   i_clk   serial bit clock, one bit per lane per rising edge
//   i_rst   synchronous active-high reset, highest priority
//   io_bus  slave side of ldtu_serializer_4lane_if (lane words, enables,
//           sync in; serial lanes, word strobe, sync ack out)

module ldtu_serializer_4lane
    import ldtu_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    ldtu_serializer_4lane_if.slave   io_bus
);

    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_load;
    logic                 r_word_strobe;
    logic                 r_sync_forced;
    logic                 r_sync_ack;
    logic [NUM_LANES-1:0] w_ser;

    // A sync forces the terminal count so the following edge is a load edge.
    // On a load edge this overrides the wrap to zero, which produces two
    // consecutive loads.
    always_comb begin
        w_load    = (r_cnt == CNT_LAST);
        w_cnt_nxt = r_cnt + 1'b1;
        if (io_bus.sync) begin
            w_cnt_nxt = CNT_LAST;
        end else if (w_load) begin
            w_cnt_nxt = '0;
        end
    end

    // The strobe is registered from the next count, so it is high exactly
    // during every terminal-count cycle, including sync-forced ones.
    // r_sync_forced marks a terminal-count cycle that a sync created; the
    // load closing such a cycle is acknowledged in the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_word_strobe <= 1'b0;
            r_sync_forced <= 1'b0;
            r_sync_ack    <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_word_strobe <= (w_cnt_nxt == CNT_LAST);
            r_sync_forced <= io_bus.sync;
            r_sync_ack    <= w_load & r_sync_forced;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ldtu_lane_shifter #(
            .RESET_VAL (lane_reset_val(g))
        ) u_shifter (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_load (w_load),
            .i_en   (io_bus.lane_en[g]),
            .i_data (io_bus.data32[g]),
            .o_ser  (w_ser[g])
        );
    end

    assign io_bus.ser         = w_ser;
    assign io_bus.word_strobe = r_word_strobe;
    assign io_bus.sync_ack    = r_sync_ack;

endmodule

// File: tb/tb_ldtu_serializer_4lane.sv
// tb/tb_ldtu_serializer_4lane.sv - self-checking bench for ldtu_serializer_4lane

module tb_ldtu_serializer_4lane;
    import ldtu_pkg::*;

    typedef logic [NUM_LANES-1:0][31:0] words_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    words_t sb[$];

    ldtu_serializer_4lane_if bus ();

    ldtu_serializer_4lane dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic words_t rand_words();
        words_t w;
        for (int l = 0; l < NUM_LANES; l++) w[l] = $urandom;
        return w;
    endfunction

    // Drive the words for the next load edge and record what should appear.
    task automatic drive_word(input words_t d, input logic [NUM_LANES-1:0] en);
        words_t e;
        bus.data32  = d;
        bus.lane_en = en;
        for (int l = 0; l < NUM_LANES; l++) e[l] = en[l] ? d[l] : 32'h0;
        sb.push_back(e);
    endtask

    // Collect n cycles of serial bits, strobe and ack (first cycle ends up highest).
    task automatic recv_bits(input int n, output words_t w, output logic [31:0] stb,
                             output logic [31:0] ack);
        w = '0;
        stb = '0;
        ack = '0;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < NUM_LANES; l++) w[l] = {w[l][30:0], bus.ser[l]};
            stb = {stb[30:0], bus.word_strobe};
            ack = {ack[30:0], bus.sync_ack};
            tick();
        end
    endtask

    task automatic test_reset();
        words_t d, w, e;
        logic [31:0] stb, ack;
        bus.sync = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.ser !== 4'b0001) begin
            n_fail++; $display("FAIL reset_ser: got %b, required %b", bus.ser, 4'b0001);
        end
        n_checks++;
        if (bus.word_strobe !== 1'b0 || bus.sync_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobe_ack: got %b%b, required 00", bus.word_strobe, bus.sync_ack);
        end
        rst = 1'b0;
        d = rand_words();
        d[0] = 32'h12345678;
        drive_word(d, 4'hF);
        recv_bits(32, w, stb, ack);
        n_checks++;
        if (w[0] !== 32'hEAAAAAAA) begin
            n_fail++; $display("FAIL idle_lane0: got %h, required %h", w[0], 32'hEAAAAAAA);
        end
        n_checks++;
        if (w[1] !== 32'h5A5A5A5A || w[3] !== 32'h5A5A5A5A) begin
            n_fail++; $display("FAIL idle_lane13: got %h %h, required 5a5a5a5a", w[1], w[3]);
        end
        n_checks++;
        if (stb !== 32'h1) begin
            n_fail++; $display("FAIL first_strobe: got %h, required %h", stb, 32'h1);
        end
        drive_word(rand_words(), 4'hF);
        recv_bits(32, w, stb, ack);
        e = sb.pop_front();
        n_checks++;
        if (w !== e) begin
            n_fail++; $display("FAIL first_word: got %h, required %h", w, e);
        end
        n_checks++;
        if (w[0] !== 32'h12345678) begin
            n_fail++; $display("FAIL first_word_lane0: got %h, required %h", w[0], 32'h12345678);
        end
    endtask

    task automatic test_lane_disable();
        words_t d, w, wa, wb, e;
        logic [31:0] stb, ack;
        d = rand_words();
        d[2] = 32'hFFFFFFFF;
        drive_word(d, 4'b1011);
        recv_bits(32, w, stb, ack);
        e = sb.pop_front();
        n_checks++;
        if (w !== e) begin
            n_fail++; $display("FAIL pre_disable_word: got %h, required %h", w, e);
        end
        // re-enable half way through the disabled word
        recv_bits(16, wa, stb, ack);
        d = rand_words();
        d[2] = 32'hFFFFFFFF;
        drive_word(d, 4'hF);
        recv_bits(16, wb, stb, ack);
        for (int l = 0; l < NUM_LANES; l++) w[l] = {wa[l][15:0], wb[l][15:0]};
        e = sb.pop_front();
        n_checks++;
        if (w !== e) begin
            n_fail++; $display("FAIL disabled_word: got %h, required %h", w, e);
        end
        n_checks++;
        if (w[2] !== 32'h0) begin
            n_fail++; $display("FAIL lane2_zero: got %h, required %h", w[2], 32'h0);
        end
        drive_word(rand_words(), 4'hF);
        recv_bits(32, w, stb, ack);
        e = sb.pop_front();
        n_checks++;
        if (w !== e || w[2] !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL lane2_reenabled: got %h, required %h", w, e);
        end
    endtask

    task automatic test_mid_sync();
        words_t dn, w, e;
        logic [31:0] stb, ack;
        dn = rand_words();
        drive_word(dn, 4'hF);
        recv_bits(10, w, stb, ack);
        e = sb.pop_front();
        for (int l = 0; l < NUM_LANES; l++) begin
            n_checks++;
            if (w[l][9:0] !== e[l][31:22]) begin
                n_fail++; $display("FAIL sync_partial lane%0d: got %h, required %h", l, w[l][9:0], e[l][31:22]);
            end
        end
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        n_checks++;
        if (bus.word_strobe !== 1'b1) begin
            n_fail++; $display("FAIL sync_strobe: got %b, required 1", bus.word_strobe);
        end
        tick();
        n_checks++;
        if (bus.ser !== {dn[3][31], dn[2][31], dn[1][31], dn[0][31]}) begin
            n_fail++; $display("FAIL sync_first_bit: got %b, required %b", bus.ser,
                               {dn[3][31], dn[2][31], dn[1][31], dn[0][31]});
        end
        drive_word(rand_words(), 4'hF);
        recv_bits(32, w, stb, ack);
        e = sb.pop_front();
        n_checks++;
        if (w !== e) begin
            n_fail++; $display("FAIL sync_word: got %h, required %h", w, e);
        end
        n_checks++;
        if (ack !== 32'h80000000) begin
            n_fail++; $display("FAIL sync_ack_once: got %h, required %h", ack, 32'h80000000);
        end
        n_checks++;
        if (stb !== 32'h1) begin
            n_fail++; $display("FAIL sync_period: got %h, required %h", stb, 32'h1);
        end
    endtask

    task automatic test_sync_on_load();
        words_t d1, d2, w, e;
        logic [31:0] stb, ack;
        d1 = rand_words();
        d1[0] = 32'h80000000;
        drive_word(d1, 4'hF);
        recv_bits(31, w, stb, ack);
        e = sb.pop_front();
        n_checks++;
        if (w[0][30:0] !== e[0][31:1] || w[3][30:0] !== e[3][31:1]) begin
            n_fail++; $display("FAIL sol_prev_word: got %h, required %h", w, e);
        end
        n_checks++;
        if (bus.word_strobe !== 1'b1) begin
            n_fail++; $display("FAIL sol_strobe: got %b, required 1", bus.word_strobe);
        end
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        d2 = rand_words();
        d2[0] = 32'hAAAAAAAA;
        drive_word(d2, 4'hF);
        e = sb.pop_front();
        n_checks++;
        if (bus.ser !== {e[3][31], e[2][31], e[1][31], e[0][31]} || bus.ser[0] !== 1'b1) begin
            n_fail++; $display("FAIL sol_single_bit: got %b, required %b", bus.ser,
                               {e[3][31], e[2][31], e[1][31], e[0][31]});
        end
        n_checks++;
        if (bus.sync_ack !== 1'b0 || bus.word_strobe !== 1'b1) begin
            n_fail++; $display("FAIL sol_between: got ack %b strobe %b, required ack 0 strobe 1",
                               bus.sync_ack, bus.word_strobe);
        end
        tick();
        drive_word(rand_words(), 4'hF);
        recv_bits(32, w, stb, ack);
        e = sb.pop_front();
        n_checks++;
        if (w !== e || w[0] !== 32'hAAAAAAAA) begin
            n_fail++; $display("FAIL sol_word: got %h, required %h", w, e);
        end
        n_checks++;
        if (ack !== 32'h80000000) begin
            n_fail++; $display("FAIL sol_ack: got %h, required %h", ack, 32'h80000000);
        end
    endtask

    task automatic test_reset_mid();
        words_t w, e;
        logic [31:0] stb, ack;
        recv_bits(17, w, stb, ack);
        e = sb.pop_front();
        n_checks++;
        if (w[0][16:0] !== e[0][31:15] || w[1][16:0] !== e[1][31:15]) begin
            n_fail++; $display("FAIL rstmid_partial: got %h, required %h", w, e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.ser !== 4'b0001 || bus.word_strobe !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state: got ser %b strobe %b, required ser 0001 strobe 0",
                               bus.ser, bus.word_strobe);
        end
        drive_word(rand_words(), 4'hF);
        recv_bits(32, w, stb, ack);
        n_checks++;
        if (w[0] !== IDLE_EA || w[2] !== IDLE_5A) begin
            n_fail++; $display("FAIL rstmid_idle: got %h %h, required %h %h", w[0], w[2], IDLE_EA, IDLE_5A);
        end
        n_checks++;
        if (stb !== 32'h1) begin
            n_fail++; $display("FAIL rstmid_count: got %h, required %h", stb, 32'h1);
        end
    endtask

    task automatic test_back_to_back();
        words_t w, e;
        logic [31:0] stb, ack;
        for (int k = 0; k < 100; k++) begin
            drive_word(rand_words(), 4'hF);
            recv_bits(32, w, stb, ack);
            e = sb.pop_front();
            n_checks++;
            if (w !== e) begin
                n_fail++; $display("FAIL b2b_word %0d: got %h, required %h", k, w, e);
            end
            n_checks++;
            if (stb !== 32'h1) begin
                n_fail++; $display("FAIL b2b_strobe %0d: got %h, required %h", k, stb, 32'h1);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.sync = 1'b0;
        bus.lane_en = 4'hF;
        bus.data32 = '0;
        test_reset();
        test_lane_disable();
        test_mid_sync();
        test_sync_on_load();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ldtu_serializer_4lane.md
# ldtu_serializer_4lane

Four-lane 32:1 serializer that sits directly downstream of the LiteDTU 32-bit output mux. It takes the four 32-bit lane words (DTU data on lane 0, ATU test data or idle pattern on lanes 1-3) and shifts each out MSB-first on its own serial line, one bit per fast clock. It generates the word-load strobe that paces the upstream mux, supports per-lane disable and a resynchronization input that re-aligns word boundaries.

## Interface
- Nbits_32, 32: lane word width; the counter and shift registers are sized from it.
- IDLE_EA, 32'hEAAAAAAA: reset content of the lane 0 shift register.
- IDLE_5A, 32'h5A5A5A5A: reset content of the lane 1-3 shift registers.
- CLK  input  1  serial bit clock; one bit per lane per rising edge.
- RST  input  1  synchronous, active-high reset; sampled on the CLK rising edge.
- DATA32_0..DATA32_3  input  Nbits_32 each  lane words from the upstream mux; sampled only on the load edge.
- LANE_EN  input  4  per-lane enable; sampled on the load edge.
- SYNC  input  1  word-boundary resync request, single-cycle pulse.
- SER_0..SER_3  output  1 each  serial lane outputs, MSB-first.
- WORD_STROBE  output  1  high during the cycle whose closing edge loads new words.
- SYNC_ACK  output  1  one-cycle pulse, the cycle after a SYNC-forced load.

## Operation
- The 5-bit bit counter cnt runs 0..31 and wraps. The four 32-bit shift registers sr_i drive SER_i = sr_i[31] directly, with no extra output flop.
- Reset (RST=1 at an edge): cnt=0, sr_0=IDLE_EA, sr_1..3=IDLE_5A, WORD_STROBE=0, SYNC_ACK=0. After reset, SER_0=1 and SER_1..3=0 (bit 31 of each pattern). RST has priority over everything else.
- Normal edge, cnt≠31: every sr_i shifts left by one with 0 shifted in, and cnt increments.
- Load edge, cnt==31:
  - sr_i ← DATA32_i if LANE_EN[i]=1, else 32'h0.
  - cnt ← 0.
- WORD_STROBE is a registered signal. It is set on the edge where cnt==30 and cleared on the next edge, so it is high exactly during the cnt==31 cycle.
- SYNC=1 at an edge with cnt≠31: sr_i shifts normally and cnt is forced to 31, so the next edge is a load edge. The partially sent word is truncated.
- SYNC=1 at an edge with cnt==31: the load happens as normal and cnt is forced to 31 instead of 0, giving two consecutive load edges. The first loaded word is then emitted for only one bit.
- SYNC_ACK is high during the cycle after any load edge that was caused by a SYNC-forced cnt=31.
- A disabled lane outputs constant 0 from its next load onward. Enable changes take effect only at a load edge, never mid-word.

## Timing
- Upstream contract: DATA32_i and LANE_EN must be stable in the cycle where WORD_STROBE=1.
- Latency: bit 31 of a loaded word appears on SER_i in the cycle immediately after the load edge. Bit 0 appears 31 cycles later.
- Word period: 32 cycles with no SYNC. The first load after reset deassertion occurs at the 32nd rising edge.
- Reset mid-word: the serial stream is abandoned at once and the idle patterns restart at bit 31 on the next cycle.
- All four lanes share cnt, so they are always bit-aligned to each other.

## Structure
- Shared package ldtu_pkg holds:
  - the idle pattern constants IDLE_EA and IDLE_5A, which are shared with the upstream mux;
  - the Nbits_32 width constant;
  - the counter width constant CNT_W = 5.
- One sub-module, ldtu_lane_shifter: a single 32-bit load/shift register with an enable-gated load and SER output, instantiated four times.
- The counter, strobe and SYNC logic stay in the top level.

## Test plan
- **Reset idle:** hold RST for 3 cycles, then release with DATA32_0 = 32'h12345678.
  - First 32 bits on SER_0 = EAAAAAAA MSB-first, and on SER_1 = 5A5A5A5A.
  - WORD_STROBE is high only in cycle 32.
  - The next 32 SER_0 bits = 12345678.
- **Lane disable:** LANE_EN = 4'b1011 with DATA32_2 = 32'hFFFFFFFF.
  - SER_2 stays 0 for the whole word.
  - The other lanes carry their words.
  - Re-enabling mid-word has no effect until the next load.
- **Mid-word SYNC:** pulse SYNC at cnt=10.
  - The next edge loads; SER shows the new word's bit 31.
  - SYNC_ACK pulses once, and the word period then resumes at 32.
- **SYNC on load edge:** SYNC at cnt==31 with DATA32_0 = 32'h80000000 and then 32'hAAAAAAAA.
  - SER_0 shows 1 for a single cycle, then AAAAAAAA in full.
- **Reset mid-word:** assert RST at cnt=17.
  - The next cycle shows SER_0=1 (EAAAAAAA bit 31), with cnt=0 and WORD_STROBE=0.
- **Back-to-back words:** 100 consecutive random words on all lanes.
  - The bench deserializer reconstructs every word exactly.
  - WORD_STROBE period is exactly 32.
